// File: rtl/gem_cluster_sequencer.sv
// GEM cluster sequencer.
// Latches the clusters of one bunch crossing and serialises the valid ones,
// lowest slot first, one per clock. Clusters still pending when the next
// crossing arrives are discarded and counted in a saturating counter.
module gem_cluster_sequencer #(
  parameter int NCLST  = 8,
  parameter int IDXB   = 3,
  parameter int MAXPAD = 191,
  parameter int OVFB   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              gem_match_enable,
  input  logic              bx_strobe,
  input  logic [NCLST*14-1:0] clusters,
  output logic [13:0]       cluster0,
  output logic              cluster0_vpf,
  output logic [2:0]        cluster0_roll,
  output logic [7:0]        cluster0_pad,
  output logic [2:0]        cluster0_size,
  output logic [IDXB-1:0]   cluster0_index,
  output logic              cluster0_last,
  output logic              busy,
  output logic [IDXB:0]     ncluster_bx,
  output logic [OVFB-1:0]   ovf_cnt
);

  localparam logic [7:0] MAXPAD_B = 8'(MAXPAD);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_reg, state_next;
  logic [13:0]       bank_reg [NCLST];
  logic [NCLST-1:0]  pending_reg, pending_next;
  logic [13:0]       cluster_reg, cluster_next;
  logic [IDXB-1:0]   index_reg, index_next;
  logic              vpf_reg, vpf_next;
  logic              last_reg, last_next;
  logic [IDXB:0]     ncl_reg, ncl_next;
  logic [OVFB-1:0]   ovf_reg, ovf_next;
  logic              bank_load;

  logic [13:0]       clus_in [NCLST];
  logic [NCLST-1:0]  valid_in;
  logic [IDXB:0]     valid_cnt;
  logic [IDXB-1:0]   emit_idx;
  logic [NCLST-1:0]  rest_mask;
  logic [IDXB:0]     rest_cnt;
  logic [OVFB:0]     ovf_sum;
  logic [OVFB-1:0]   ovf_sat;

  // Unpack the input bus and flag clusters whose pad is in range.
  for (genvar gi = 0; gi < NCLST; gi++) begin : g_slot
    assign clus_in[gi]  = clusters[14*gi +: 14];
    assign valid_in[gi] = (clusters[14*gi +: 8] <= MAXPAD_B);
  end

  // Count of valid clusters in the incoming crossing.
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < NCLST; i++) begin
      valid_cnt = valid_cnt + (IDXB+1)'(valid_in[i]);
    end
  end

  // Lowest pending slot, the mask left after emitting it, and its population.
  always_comb begin
    emit_idx = '0;
    for (int i = NCLST - 1; i >= 0; i--) begin
      if (pending_reg[i]) emit_idx = IDXB'(i);
    end
    rest_mask = pending_reg & ~({{(NCLST-1){1'b0}}, 1'b1} << emit_idx);
    rest_cnt  = '0;
    for (int i = 0; i < NCLST; i++) begin
      rest_cnt = rest_cnt + (IDXB+1)'(rest_mask[i]);
    end
  end

  // Overflow counter increment, clamped at all-ones.
  always_comb begin
    ovf_sum = {1'b0, ovf_reg} + (OVFB+1)'(rest_cnt);
    ovf_sat = ovf_sum[OVFB] ? {OVFB{1'b1}} : ovf_sum[OVFB-1:0];
  end

  // Next-state and emission logic; a strobe overrides whatever is left pending.
  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    cluster_next = cluster_reg;
    index_next   = index_reg;
    vpf_next     = 1'b0;
    last_next    = 1'b0;
    ncl_next     = ncl_reg;
    ovf_next     = ovf_reg;
    bank_load    = 1'b0;

    if (!gem_match_enable) begin
      pending_next = '0;
      state_next   = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
        end
        SCAN: begin
          cluster_next = bank_reg[emit_idx];
          index_next   = emit_idx;
          vpf_next     = 1'b1;
          // A strobe cuts the current set short, so this emission ends it.
          last_next    = (rest_mask == '0) || bx_strobe;
          pending_next = rest_mask;
        end
        default: begin
        end
      endcase

      if (bx_strobe) begin
        bank_load    = 1'b1;
        pending_next = valid_in;
        ncl_next     = valid_cnt;
        if (rest_mask != '0) ovf_next = ovf_sat;
      end

      state_next = (pending_next != '0) ? SCAN : IDLE;
    end
  end

  // State, cluster bank and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      cluster_reg <= '0;
      index_reg   <= '0;
      vpf_reg     <= 1'b0;
      last_reg    <= 1'b0;
      ncl_reg     <= '0;
      ovf_reg     <= '0;
      for (int i = 0; i < NCLST; i++) bank_reg[i] <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      cluster_reg <= cluster_next;
      index_reg   <= index_next;
      vpf_reg     <= vpf_next;
      last_reg    <= last_next;
      ncl_reg     <= ncl_next;
      ovf_reg     <= ovf_next;
      if (bank_load) begin
        for (int i = 0; i < NCLST; i++) bank_reg[i] <= clus_in[i];
      end
    end
  end

  assign cluster0       = cluster_reg;
  assign cluster0_size  = cluster_reg[13:11];
  assign cluster0_roll  = cluster_reg[10:8];
  assign cluster0_pad   = cluster_reg[7:0];
  assign cluster0_index = index_reg;
  assign cluster0_vpf   = vpf_reg;
  assign cluster0_last  = last_reg;
  assign busy           = (pending_reg != '0);
  assign ncluster_bx    = ncl_reg;
  assign ovf_cnt        = ovf_reg;

endmodule

// File: tb/tb_gem_cluster_sequencer.sv
// Testbench for gem_cluster_sequencer: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_gem_cluster_sequencer;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         gem_match_enable = 1'b0;
  logic         bx_strobe = 1'b0;
  logic [111:0] clusters = '0;
  logic [13:0]  cluster0;
  logic         cluster0_vpf;
  logic [2:0]   cluster0_roll;
  logic [7:0]   cluster0_pad;
  logic [2:0]   cluster0_size;
  logic [2:0]   cluster0_index;
  logic         cluster0_last;
  logic         busy;
  logic [3:0]   ncluster_bx;
  logic [7:0]   ovf_cnt;

  gem_cluster_sequencer dut (
    .clock(clock), .reset_n(reset_n), .gem_match_enable(gem_match_enable),
    .bx_strobe(bx_strobe), .clusters(clusters), .cluster0(cluster0),
    .cluster0_vpf(cluster0_vpf), .cluster0_roll(cluster0_roll),
    .cluster0_pad(cluster0_pad), .cluster0_size(cluster0_size),
    .cluster0_index(cluster0_index), .cluster0_last(cluster0_last),
    .busy(busy), .ncluster_bx(ncluster_bx), .ovf_cnt(ovf_cnt)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: latched bank plus an ordered queue of pending slots.
  logic [13:0] m_bank [8];
  int          pq [$];
  logic [13:0] e_cl   = '0;
  int          e_idx  = 0;
  int          e_vpf  = 0;
  int          e_last = 0;
  int          e_ncl  = 0;
  int          e_ovf  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < 8; i++) m_bank[i] = '0;
    e_cl = '0; e_idx = 0; e_vpf = 0; e_last = 0; e_ncl = 0; e_ovf = 0;
  endtask

  task automatic model_step(input bit r, input bit en, input bit stb, input logic [111:0] cl);
    if (!r) begin
      model_reset();
      return;
    end
    if (!en) begin
      pq.delete();
      e_vpf = 0; e_last = 0;
      return;
    end
    if (pq.size() > 0) begin
      int i;
      i      = pq.pop_front();
      e_cl   = m_bank[i];
      e_idx  = i;
      e_vpf  = 1;
      e_last = ((pq.size() == 0) || stb) ? 1 : 0;
    end else begin
      e_vpf = 0; e_last = 0;
    end
    if (stb) begin
      e_ovf = e_ovf + pq.size();
      if (e_ovf > 255) e_ovf = 255;
      pq.delete();
      for (int i = 0; i < 8; i++) begin
        m_bank[i] = cl[14*i +: 14];
        if (cl[14*i +: 8] <= 8'd191) pq.push_back(i);
      end
      e_ncl = pq.size();
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("cluster0", int'(cluster0), int'(e_cl));
    chk("size", int'(cluster0_size), int'(e_cl[13:11]));
    chk("roll", int'(cluster0_roll), int'(e_cl[10:8]));
    chk("pad", int'(cluster0_pad), int'(e_cl[7:0]));
    chk("index", int'(cluster0_index), e_idx);
    chk("vpf", int'(cluster0_vpf), e_vpf);
    chk("last", int'(cluster0_last), e_last);
    chk("busy", int'(busy), (pq.size() != 0) ? 1 : 0);
    chk("ncluster_bx", int'(ncluster_bx), e_ncl);
    chk("ovf_cnt", int'(ovf_cnt), e_ovf);
  end

  // Apply inputs just after a falling edge, predict the next rising edge,
  // and return just after the following falling edge.
  task automatic tick(input bit r, input bit en, input bit stb, input logic [111:0] cl);
    reset_n = r; gem_match_enable = en; bx_strobe = stb; clusters = cl;
    model_step(r, en, stb, cl);
    @(negedge clock);
    #1;
  endtask

  function automatic logic [13:0] mk(input int sz, input int rl, input int pd);
    return {sz[2:0], rl[2:0], pd[7:0]};
  endfunction

  function automatic logic [111:0] put(input logic [111:0] v, input int i, input logic [13:0] w);
    logic [111:0] r;
    r = v;
    r[14*i +: 14] = w;
    return r;
  endfunction

  function automatic logic [111:0] rand_clusters();
    logic [111:0] v;
    int mode;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0)      v = put(v, i, mk($urandom_range(0,7), $urandom_range(0,7), 255));
      else if (mode == 1) v = put(v, i, mk($urandom_range(0,7), $urandom_range(0,7), $urandom_range(192,254)));
      else                v = put(v, i, mk($urandom_range(0,7), $urandom_range(0,7), $urandom_range(0,191)));
    end
    if ($urandom_range(0, 9) == 0) begin
      for (int i = 0; i < 8; i++) v = put(v, i, mk(0, 0, 255));
    end
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [111:0] allff, all8, set3, s146, v;
    allff = '0;
    for (int i = 0; i < 8; i++) allff = put(allff, i, mk(0, 0, 255));
    all8 = '0;
    for (int i = 0; i < 8; i++) all8 = put(all8, i, mk(i, 7 - i, 10 + 20 * i));
    set3 = allff;
    set3 = put(set3, 0, mk(1, 1, 5));
    set3 = put(set3, 2, mk(2, 3, 77));
    set3 = put(set3, 5, mk(7, 7, 0));
    s146 = allff;
    s146 = put(s146, 1, mk(0, 1, 10));
    s146 = put(s146, 4, mk(2, 0, 20));
    s146 = put(s146, 6, mk(4, 5, 30));

    model_reset();
    @(negedge clock); #1;
    chk("reset_vpf", int'(cluster0_vpf), 0);
    chk("reset_cluster0", int'(cluster0), 0);
    chk("reset_ovf", int'(ovf_cnt), 0);
    tick(1, 1, 0, allff);

    // Slots 1,4,6 valid.
    tick(1, 1, 1, s146);
    chk("t1_vpf_at_T", int'(cluster0_vpf), 0);
    chk("t1_ncl", int'(ncluster_bx), 3);
    tick(1, 1, 0, allff);
    chk("t1_idx_a", int'(cluster0_index), 1);
    chk("t1_pad_a", int'(cluster0_pad), 10);
    chk("t1_last_a", int'(cluster0_last), 0);
    tick(1, 1, 0, allff);
    chk("t1_idx_b", int'(cluster0_index), 4);
    chk("t1_last_b", int'(cluster0_last), 0);
    tick(1, 1, 0, allff);
    chk("t1_idx_c", int'(cluster0_index), 6);
    chk("t1_last_c", int'(cluster0_last), 1);
    chk("t1_busy_c", int'(busy), 0);
    tick(1, 1, 0, allff);
    chk("t1_vpf_done", int'(cluster0_vpf), 0);

    // All 8 valid, interrupted at T+5, then a strobe on the final emission.
    tick(1, 1, 1, all8);
    for (int k = 0; k < 4; k++) tick(1, 1, 0, allff);
    tick(1, 1, 1, set3);
    chk("t2_idx_T5", int'(cluster0_index), 4);
    chk("t2_last_T5", int'(cluster0_last), 1);
    chk("t2_ovf", int'(ovf_cnt), 3);
    tick(1, 1, 0, allff);
    chk("t2_idx_T6", int'(cluster0_index), 0);
    chk("t2_vpf_T6", int'(cluster0_vpf), 1);
    tick(1, 1, 0, allff);
    tick(1, 1, 1, s146);
    chk("t2_idx_T8", int'(cluster0_index), 5);
    chk("t2_last_T8", int'(cluster0_last), 1);
    chk("t2_ovf_kept", int'(ovf_cnt), 3);
    for (int k = 0; k < 4; k++) tick(1, 1, 0, allff);

    // Pad boundary: 192 invalid, 191 valid.
    v = allff;
    v = put(v, 0, mk(5, 2, 192));
    v = put(v, 1, mk(3, 6, 191));
    tick(1, 1, 1, v);
    chk("t3_ncl", int'(ncluster_bx), 1);
    tick(1, 1, 0, allff);
    chk("t3_idx", int'(cluster0_index), 1);
    chk("t3_pad", int'(cluster0_pad), 191);
    chk("t3_roll", int'(cluster0_roll), 6);
    chk("t3_size", int'(cluster0_size), 3);
    chk("t3_last", int'(cluster0_last), 1);
    tick(1, 1, 0, allff);

    // Enable dropped mid-drain.
    tick(1, 1, 1, all8);
    tick(1, 1, 0, allff);
    tick(1, 1, 0, allff);
    tick(1, 0, 0, allff);
    chk("t4_vpf_off", int'(cluster0_vpf), 0);
    chk("t4_busy_off", int'(busy), 0);
    tick(1, 0, 1, all8);
    tick(1, 0, 0, allff);
    chk("t4_ignored", int'(cluster0_vpf), 0);
    tick(1, 1, 1, s146);
    tick(1, 1, 0, allff);
    chk("t4_resume", int'(cluster0_index), 1);
    for (int k = 0; k < 3; k++) tick(1, 1, 0, allff);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) == 0), rand_clusters());
    end
    tick(1, 1, 0, allff);

    // Reset asserted during an 8-cluster drain.
    tick(1, 1, 1, all8);
    tick(1, 1, 0, allff);
    tick(1, 1, 0, allff);
    reset_n = 1'b0;
    #1;
    chk("t5_async_vpf", int'(cluster0_vpf), 0);
    chk("t5_async_cl", int'(cluster0), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_ncl", int'(ncluster_bx), 0);
    model_reset();
    tick(0, 1, 0, allff);
    for (int k = 0; k < 5; k++) begin
      tick(1, 1, 0, allff);
      chk("t5_quiet", int'(cluster0_vpf), 0);
    end
    tick(1, 1, 1, s146);
    tick(1, 1, 0, allff);
    chk("t5_restart", int'(cluster0_index), 1);
    for (int k = 0; k < 3; k++) tick(1, 1, 0, allff);

    // Saturate the overflow counter: 7 drops per strobe after the first.
    for (int k = 0; k < 45; k++) tick(1, 1, 1, all8);
    chk("t6_sat", int'(ovf_cnt), 255);
    tick(1, 1, 1, all8);
    chk("t6_sat_hold", int'(ovf_cnt), 255);
    for (int k = 0; k < 10; k++) tick(1, 1, 0, allff);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
